wb_ext_arbiter: RTL

//  Shares one external Wishbone slave (e.g. a board SRAM/DDR bridge) among the NODES per-tile
//  wb_ext master ports that the distributed-memory system exports. Uses round-robin arbitration.

---
 rtl/wb_ext_arbiter_pkg.sv | 19 +
 rtl/wb_ext_arbiter_rr.sv | 29 ++
 rtl/wb_ext_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_ext_arbiter_pkg.sv
// Shared types and constants for the external Wishbone round-robin arbiter.
// Optional watchdog is enabled with the WB_ARB_TIMEOUT_EN macro.
package wb_ext_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } wb_arb_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    // Pointer width that stays legal for a single master.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_ext_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping modulo NODES, returned as a one-hot grant.
module arb_rr
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NODES = 1,
    localparam int PW = ptr_width(NODES)
) (
    input  logic [NODES-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NODES-1:0] gnt
);

    always_comb begin
        int idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NODES; i++) begin
            idx = (int'(ptr) + i) % NODES;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Shares one external Wishbone slave among NODES masters, holding the grant
// for a whole cyc; the WB_ARB_TIMEOUT_EN macro adds a slave watchdog.
module wb_ext_arbiter
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NODES   = 1,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NODES*AW-1:0]    m_adr_i,
    input  logic [NODES*DW-1:0]    m_dat_i,
    input  logic [NODES*DW/8-1:0]  m_sel_i,
    input  logic [NODES-1:0]       m_cyc_i,
    input  logic [NODES-1:0]       m_stb_i,
    input  logic [NODES-1:0]       m_we_i,
    input  logic [NODES-1:0]       m_cab_i,
    input  logic [NODES*3-1:0]     m_cti_i,
    input  logic [NODES*2-1:0]     m_bte_i,
    output logic [NODES-1:0]       m_ack_o,
    output logic [NODES-1:0]       m_rty_o,
    output logic [NODES-1:0]       m_err_o,
    output logic [NODES*DW-1:0]    m_dat_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [DW/8-1:0]        s_sel_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic                   s_cab_o,
    output logic [2:0]             s_cti_o,
    output logic [1:0]             s_bte_o,
    input  logic                   s_ack_i,
    input  logic                   s_rty_i,
    input  logic                   s_err_i,
    input  logic [DW-1:0]          s_dat_i,
    output logic [NODES-1:0]       grant_o
);

    localparam int SW = DW / 8;
    localparam int PW = ptr_width(NODES);
    localparam logic [PW-1:0] LAST = PW'(NODES - 1);

    wb_arb_state_t    state, state_d;
    logic [NODES-1:0] grant, grant_d;
    logic [PW-1:0]    ptr, ptr_d;
    logic [PW-1:0]    g_idx;
    logic [NODES-1:0] rr_gnt;
    logic             own_cyc;
    logic             own_stb;
    logic             term;
    logic             timeout;

    arb_rr #(
        .NODES(NODES)
    ) u_rr (
        .req(m_cyc_i),
        .ptr(ptr),
        .gnt(rr_gnt)
    );

    // One-hot grant makes an OR-mux sufficient; grant is 0 while idle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        g_idx   = '0;
        for (int n = 0; n < NODES; n++) begin
            if (grant[n]) begin
                s_adr_o |= m_adr_i[n*AW +: AW];
                s_dat_o |= m_dat_i[n*DW +: DW];
                s_sel_o |= m_sel_i[n*SW +: SW];
                s_cti_o |= m_cti_i[n*3 +: 3];
                s_bte_o |= m_bte_i[n*2 +: 2];
                s_we_o  |= m_we_i[n];
                s_cab_o |= m_cab_i[n];
                own_cyc |= m_cyc_i[n];
                own_stb |= m_stb_i[n];
                g_idx   |= PW'(n);
            end
        end
    end

    assign s_cyc_o = own_cyc & ~timeout;
    assign s_stb_o = own_stb & ~timeout;
    assign term    = s_ack_i | s_rty_i | s_err_i;

    assign m_ack_o = grant & {NODES{s_ack_i}};
    assign m_rty_o = grant & {NODES{s_rty_i}};
    assign m_err_o = grant & {NODES{s_err_i | timeout}};
    assign m_dat_o = {NODES{s_dat_i}};
    assign grant_o = grant;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] wd_cnt;
    logic          waiting;

    assign waiting = (state == ARB_BUSY) & own_stb & ~term;
    assign timeout = waiting & (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != ARB_BUSY || term || timeout) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            ptr   <= ptr_d;
        end
    end

    // Release is taken before any new arbitration, forcing an idle cycle.
    always_comb begin
        state_d = state;
        grant_d = grant;
        ptr_d   = ptr;
        unique case (state)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = rr_gnt;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!own_cyc || timeout) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                    ptr_d   = (g_idx == LAST) ? '0 : g_idx + 1'b1;
                end
            end
        endcase
    end

endmodule
